fp_unit_controller: RTL
=======================

# fp_unit_controller

Sequencer sitting between the FP issue stage and the FP execution unit. It accepts one FP operation at a time, resolves the rounding mode, drives enable/unit/command/flush into the FP unit, waits for `done` (one cycle for most units, many for sqrt) and captures the result. It also accumulates sticky fflags for the CSR file and returns the result through a valid/ready response port.

## Interface
Parameters:
- `FP_WIDTH`, 32, width of FP results.
- `MAX_CYCLES`, 64, EXEC watchdog limit in cycles (≥ 2).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `reqValid`  in  1  issue request valid.
- `reqReady`  out  1  controller can accept a request.
- `reqUnit`  in  FpUnitType  target unit.
- `reqCommand`  in  FpUnitCommand  per-unit command.
- `reqRm`  in  3  instruction rm field (3'b111 = dynamic).
- `reqRd`  in  5  destination register.
- `reqIntDest`  in  1  result goes to integer register file.
- `csrFrm`  in  3  current frm CSR value.
- `opCapture`  out  1  one-cycle strobe telling the operand register to latch fpSrc1..3 and intSrc1..2.
- `fpuEnable`  out  1  FP unit enable.
- `fpuFlush`  out  1  FP unit flush.
- `fpuUnit`  out  FpUnitType  registered unit select.
- `fpuCommand`  out  FpUnitCommand  registered command.
- `fpuRoundingMode`  out  3  resolved rounding mode.
- `fpuDone`  in  1  FP unit result ready.
- `fpuWriteFlags`  in  1  flags valid with the result.
- `fpuFlagsValue`  in  5  fflags from the unit.
- `fpuIntResult`  in  32  integer result.
- `fpuFpResult`  in  FP_WIDTH  FP result.
- `flush`  in  1  pipeline flush.
- `respValid`  out  1  response valid.
- `respReady`  in  1  consumer accepts the response.
- `respResult`  out  FP_WIDTH  result; the integer result is zero-extended or truncated to FP_WIDTH.
- `respRd`  out  5  destination register.
- `respIntDest`  out  1  copy of reqIntDest.
- `respIllegal`  out  1  invalid rounding mode; result is 0.
- `respTimeout`  out  1  watchdog expired; result is 0.
- `fflags`  out  5  accumulated sticky flags.
- `fflagsClear`  in  1  clear the fflags accumulator (CSR write).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `reqReady`=1. When `reqValid && !flush`:
  - register unit, command, rd and intDest;
  - resolve rm as (`reqRm`==7 ? `csrFrm` : `reqRm`);
  - pulse `opCapture`.
  - If the resolved rm is 5, 6 or 7: go to RESP with illegal=1 and result 0; the FP unit is never enabled.
  - Otherwise go to EXEC and clear the cycle counter.
- EXEC: `fpuEnable`=1 and `reqReady`=0. The counter increments each cycle. On `fpuDone`:
  - capture `respResult` (fpuIntResult if intDest, else fpuFpResult);
  - if `fpuWriteFlags`, OR `fpuFlagsValue` into `fflags`;
  - go to RESP.
- Watchdog: if the counter reaches MAX_CYCLES-1 without `fpuDone`, pulse `fpuFlush` for 1 cycle, set timeout=1, result 0, and go to RESP. Flags are not accumulated.
- RESP: `respValid`=1; `resp*` fields are held stable. On `respReady`, go to IDLE.
- `flush` in any state: next state is IDLE. In EXEC it also drives `fpuFlush`=1 and `fpuEnable`=0 that cycle, and flags are not accumulated. In RESP the response is dropped.
- Simultaneous events:
  - `flush` and `fpuDone` in EXEC: flush wins; no flags, no response.
  - `flush` and `respReady` in RESP: go to IDLE (same outcome).
  - `fflagsClear` and a flag update in the same cycle: `fflags` = `fpuFlagsValue` (clear applied first).
- `fflags` is not affected by `flush`; only `rst` and `fflagsClear` clear it.

## Timing
- Reset values: state IDLE, `reqReady`=1; all other outputs 0, including `fflags`, `resp*`, `fpuUnit`/`fpuCommand`/`fpuRoundingMode`, and the counter.
- Request accepted in cycle N. `fpuEnable` is high from N+1.
- Single-cycle unit (`fpuDone` in N+1): `respValid` in N+2; next accept no earlier than the cycle after `respReady`.
- Sqrt with `fpuDone` in cycle N+k: `respValid` in N+k+1.
- `fpuUnit`, `fpuCommand` and `fpuRoundingMode` are registered and stable for the whole of EXEC.
- `fflags` updates one cycle after the `fpuDone` cycle.
- Illegal rm: `respValid` in N+1.
- Watchdog: `fpuFlush` in cycle N+MAX_CYCLES, `respValid`/`respTimeout` in N+MAX_CYCLES+1.
- Back-to-back: `reqReady` is 0 during EXEC and RESP; there is no same-cycle turnaround.

## Test plan
- MulAdd, rm=0, intDest=0. FP unit returns done in the same cycle with fpResult=32'h40490FDB and flags=5'b00001 → `respValid` at N+2 with result 32'h40490FDB; `fflags`=5'b00001.
- Dynamic rm: reqRm=7, csrFrm=3 → `fpuRoundingMode`=3. With csrFrm=5 → `respIllegal`=1 at N+1, result 0, `fpuEnable` never asserted.
- Sqrt with done after 20 cycles and flush asserted at cycle 10 → `fpuFlush` pulses at cycle 10; state IDLE at 11; no `respValid`; `fflags` unchanged.
- Sqrt with MAX_CYCLES=8 and done never asserted → `fpuFlush` at N+8; `respTimeout`=1 at N+9.
- `respReady` held low for 5 cycles in RESP → `respResult`/`respRd` stable and `reqReady`=0 throughout; IDLE the cycle after `respReady`.
- `fflagsClear` in the same cycle as a compare's flags 5'b10000 → `fflags`=5'b10000. Asserting `rst` mid-EXEC → all outputs return to reset values immediately (asynchronous).

Source files
------------

// File: rtl/fp_unit_controller_if.sv
// fp_unit_controller_if
//   Bundles the issue request, FP execution unit, response and fflags signals
//   of the FP unit controller.
//   Modports:
//     slave  - the controller: takes requests and unit results, and drives the
//              unit controls, the response and fflags.
//     master - the surrounding pipeline/environment (issue stage, FP unit, CSR
//              file, response consumer).
//   Parameters: FP_WIDTH (result width), UNIT_W / CMD_W (unit select and
//   command widths).
interface fp_unit_controller_if #(
  parameter int FP_WIDTH = 32,
  parameter int UNIT_W   = 3,
  parameter int CMD_W    = 4
);
  // issue request
  logic                reqValid;
  logic                reqReady;
  logic [UNIT_W-1:0]   reqUnit;
  logic [CMD_W-1:0]    reqCommand;
  logic [2:0]          reqRm;
  logic [4:0]          reqRd;
  logic                reqIntDest;
  logic [2:0]          csrFrm;
  logic                opCapture;
  // FP execution unit
  logic                fpuEnable;
  logic                fpuFlush;
  logic [UNIT_W-1:0]   fpuUnit;
  logic [CMD_W-1:0]    fpuCommand;
  logic [2:0]          fpuRoundingMode;
  logic                fpuDone;
  logic                fpuWriteFlags;
  logic [4:0]          fpuFlagsValue;
  logic [31:0]         fpuIntResult;
  logic [FP_WIDTH-1:0] fpuFpResult;
  // pipeline flush
  logic                flush;
  // response
  logic                respValid;
  logic                respReady;
  logic [FP_WIDTH-1:0] respResult;
  logic [4:0]          respRd;
  logic                respIntDest;
  logic                respIllegal;
  logic                respTimeout;
  // sticky flags
  logic [4:0]          fflags;
  logic                fflagsClear;

  modport slave (
    input  reqValid, reqUnit, reqCommand, reqRm, reqRd, reqIntDest, csrFrm,
    input  fpuDone, fpuWriteFlags, fpuFlagsValue, fpuIntResult, fpuFpResult,
    input  flush, respReady, fflagsClear,
    output reqReady, opCapture,
    output fpuEnable, fpuFlush, fpuUnit, fpuCommand, fpuRoundingMode,
    output respValid, respResult, respRd, respIntDest, respIllegal, respTimeout,
    output fflags
  );

  modport master (
    output reqValid, reqUnit, reqCommand, reqRm, reqRd, reqIntDest, csrFrm,
    output fpuDone, fpuWriteFlags, fpuFlagsValue, fpuIntResult, fpuFpResult,
    output flush, respReady, fflagsClear,
    input  reqReady, opCapture,
    input  fpuEnable, fpuFlush, fpuUnit, fpuCommand, fpuRoundingMode,
    input  respValid, respResult, respRd, respIntDest, respIllegal, respTimeout,
    input  fflags
  );
endinterface

// File: rtl/fp_unit_controller.sv
// fp_unit_controller
//   Sequences one FP operation at a time between the issue stage and the FP
//   execution unit: resolves the rounding mode, drives the unit while it
//   executes, guards it with a watchdog, captures the result and returns it
//   through a valid/ready response port. Also keeps the sticky fflags.
//   Ports:
//     clk  - clock
//     rst  - asynchronous active-high reset
//     bus  - fp_unit_controller_if.slave (request, FP unit, response, fflags)
//   Parameters: FP_WIDTH (must match the interface), MAX_CYCLES (>= 2).
module fp_unit_controller #(
  parameter int FP_WIDTH   = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_unit_controller_if.slave   bus
);
  localparam int CNT_W = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [2:0]          rm_resolved;
  logic                rm_illegal;
  logic                accept;
  logic                exec_done;
  logic                exec_timeout;
  logic                flag_update;
  logic [FP_WIDTH-1:0] int_ext;

  // 3'b111 in the instruction selects the dynamic mode from frm; 5..7 after
  // resolution are reserved encodings.
  assign rm_resolved  = (bus.reqRm == 3'b111) ? bus.csrFrm : bus.reqRm;
  assign rm_illegal   = (rm_resolved >= 3'd5);
  assign accept       = (state_reg == IDLE) && bus.reqValid && !bus.flush;
  // A pipeline flush in EXEC overrides both completion and the watchdog.
  assign exec_done    = (state_reg == EXEC) && !bus.flush && bus.fpuDone;
  assign exec_timeout = (state_reg == EXEC) && !bus.flush && !bus.fpuDone &&
                        (cnt_reg == CNT_LAST);
  assign flag_update  = exec_done && bus.fpuWriteFlags;

  // Integer results are zero-extended or truncated to the response width.
  generate
    if (FP_WIDTH > 32) begin : g_int_wide
      assign int_ext = {{(FP_WIDTH-32){1'b0}}, bus.fpuIntResult};
    end else if (FP_WIDTH == 32) begin : g_int_same
      assign int_ext = bus.fpuIntResult;
    end else begin : g_int_narrow
      assign int_ext = bus.fpuIntResult[FP_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    bus.reqReady  = 1'b0;
    bus.opCapture = 1'b0;
    bus.fpuEnable = 1'b0;
    bus.fpuFlush  = 1'b0;
    bus.respValid = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.reqReady = 1'b1;
        if (accept) begin
          bus.opCapture = 1'b1;
          state_next    = rm_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (bus.flush) begin
          bus.fpuFlush = 1'b1;
          state_next   = IDLE;
        end else begin
          bus.fpuEnable = 1'b1;
          if (bus.fpuDone) begin
            state_next = RESP;
          end else if (cnt_reg == CNT_LAST) begin
            bus.fpuFlush = 1'b1;
            state_next   = RESP;
          end
        end
      end
      RESP: begin
        bus.respValid = 1'b1;
        if (bus.flush || bus.respReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= IDLE;
      cnt_reg             <= '0;
      bus.fpuUnit         <= '0;
      bus.fpuCommand      <= '0;
      bus.fpuRoundingMode <= '0;
      bus.respResult      <= '0;
      bus.respRd          <= '0;
      bus.respIntDest     <= 1'b0;
      bus.respIllegal     <= 1'b0;
      bus.respTimeout     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        bus.fpuUnit         <= bus.reqUnit;
        bus.fpuCommand      <= bus.reqCommand;
        bus.fpuRoundingMode <= rm_resolved;
        cnt_reg             <= '0;
        bus.respRd          <= bus.reqRd;
        bus.respIntDest     <= bus.reqIntDest;
        bus.respIllegal     <= rm_illegal;
        bus.respTimeout     <= 1'b0;
        bus.respResult      <= '0;
      end else if (state_reg == EXEC) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (exec_done) begin
          bus.respResult <= bus.respIntDest ? int_ext : bus.fpuFpResult;
        end else if (exec_timeout) begin
          bus.respTimeout <= 1'b1;
          bus.respResult  <= '0;
        end
      end
    end
  end

  // Sticky flags; a clear in the same cycle as an update keeps only the new
  // flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.fflags <= '0;
    end else if (bus.fflagsClear) begin
      bus.fflags <= flag_update ? bus.fpuFlagsValue : 5'b0;
    end else if (flag_update) begin
      bus.fflags <= bus.fflags | bus.fpuFlagsValue;
    end
  end
endmodule
